dmem_apb_ctrl: RTL and testbench

Data-memory access controller for the NanoQuarter core: sequences every load/store onto the APB data-memory slave and shares that slave between two requesters, the pipeline memory stage and a debug/loader port. It replaces the ad-hoc memenable/memselect/memwrite glue at processor top level with a registered APB master FSM. It also drives the pipeline stall while a pipeline access is outstanding. Bus errors and hung slaves are bounded by a timeout.

---
 rtl/dmem_apb_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_apb_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_apb_ctrl.sv
// dmem_apb_ctrl: data-memory access controller.
// Arbitrates the pipeline memory stage and the debug/loader port onto a
// single APB data-memory slave through a registered four-state APB master.
// It also raises the pipeline stall while a pipeline access is outstanding
// and bounds hung or erroring slaves with a wait-state timeout.
module dmem_apb_ctrl #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15   // legal range 1..255
) (
  input  logic              clk,
  input  logic              rst,         // asynchronous, active low

  // pipeline memory-stage requester
  input  logic              pipe_req,
  input  logic              pipe_wr,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_done,
  output logic              stall_flg,

  // debug / loader requester
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,

  // shared completion status
  output logic              resp_err,

  // APB master
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // requester ids
  localparam logic GNT_PIPE = 1'b0;
  localparam logic GNT_DBG  = 1'b1;

  // wait counter is 8 bits wide; TIMEOUT is limited to 1..255
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0]        state_q,      state_d;
  logic              gnt_q,        gnt_d;
  logic              last_grant_q, last_grant_d;
  logic              wr_q,         wr_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic              err_q,        err_d;
  logic [7:0]        wait_cnt_q,   wait_cnt_d;
  logic [DATA_W-1:0] pipe_rdata_q, pipe_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q,  dbg_rdata_d;

  // load-data capture strobe and value from the ACCESS phase
  logic              cap_en;
  logic [DATA_W-1:0] cap_data;

  // Next-state: arbitration, APB sequencing, timeout and read capture
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    wait_cnt_d   = wait_cnt_q;
    pipe_rdata_d = pipe_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    cap_en       = 1'b0;
    cap_data     = '0;

    case (state_q)
      ST_IDLE: begin
        if (pipe_req || dbg_req) begin
          // on contention the requester not served last wins
          if (pipe_req && dbg_req) begin
            gnt_d = ~last_grant_q;
          end else if (dbg_req) begin
            gnt_d = GNT_DBG;
          end else begin
            gnt_d = GNT_PIPE;
          end

          if (gnt_d == GNT_DBG) begin
            wr_d    = dbg_wr;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            wr_d    = pipe_wr;
            addr_d  = pipe_addr;
            wdata_d = pipe_wdata;
          end

          err_d      = 1'b0;
          wait_cnt_d = '0;
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready) begin
          err_d   = pslverr;
          state_d = ST_DONE;
          if (!wr_q) begin
            cap_en   = 1'b1;
            cap_data = pslverr ? '0 : prdata;
          end
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          // slave hung: abort as a failed transfer
          err_d   = 1'b1;
          state_d = ST_DONE;
          if (!wr_q) begin
            cap_en   = 1'b1;
            cap_data = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        last_grant_d = gnt_q;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // only the granted requester's read register moves
    if (cap_en) begin
      if (gnt_q == GNT_DBG) begin
        dbg_rdata_d = cap_data;
      end else begin
        pipe_rdata_d = cap_data;
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= GNT_PIPE;
      last_grant_q <= GNT_DBG;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      wait_cnt_q   <= '0;
      pipe_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      wait_cnt_q   <= wait_cnt_d;
      pipe_rdata_q <= pipe_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Output decode: APB controls and done pulses come straight from state
  always_comb begin
    psel       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    penable    = (state_q == ST_ACCESS);
    pwrite     = wr_q;
    paddr      = addr_q;
    pwdata     = wdata_q;
    pipe_done  = (state_q == ST_DONE) && (gnt_q == GNT_PIPE);
    dbg_done   = (state_q == ST_DONE) && (gnt_q == GNT_DBG);
    resp_err   = (state_q == ST_DONE) && err_q;
    pipe_rdata = pipe_rdata_q;
    dbg_rdata  = dbg_rdata_q;
    stall_flg  = pipe_req & ~pipe_done;
  end

endmodule

// File: tb/tb_dmem_apb_ctrl.sv
// Testbench for dmem_apb_ctrl: APB slave model with a small memory,
// a completion scoreboard, a vector table and hand-written corner sequences.
module tb_dmem_apb_ctrl;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pipe_req = 1'b0, pipe_wr = 1'b0;
  logic [AW-1:0] pipe_addr = '0;
  logic [DW-1:0] pipe_wdata = '0;
  logic [DW-1:0] pipe_rdata;
  logic          pipe_done, stall_flg;
  logic          dbg_req = 1'b0, dbg_wr = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_done, resp_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0, pslverr = 1'b0;

  dmem_apb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .pipe_req(pipe_req), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_done(pipe_done),
    .stall_flg(stall_flg),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .resp_err(resp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // one transfer: who 0 = pipeline, 1 = debug
  typedef struct {
    bit            who;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;      // slave wait states; above TO means never ready
    bit            err;        // slave reports pslverr with pready
    logic [DW-1:0] exp_rdata;  // requester's rdata expected at done
    bit            exp_err;
    int            exp_lat;    // cycles from request cycle to done cycle
  } vec_t;

  typedef struct {
    vec_t v;
    int   issue;
  } sb_t;

  sb_t           sb[$];
  logic [DW-1:0] mem[64];
  logic [DW-1:0] last_rd[2];
  vec_t          tbl[12];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // completion monitor: every done pulse must match the scoreboard head
  always @(negedge clk) begin
    sb_t r;
    if (rst) begin
      if (pipe_done || dbg_done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: pipe_done=%0b dbg_done=%0b with empty scoreboard (cycle %0d)",
                   pipe_done, dbg_done, cyc);
        end else begin
          r = sb.pop_front();
          chk("done_both", 32'(pipe_done & dbg_done), 32'd0);
          chk("done_who", 32'(dbg_done), 32'(r.v.who));
          chk("rdata", 32'(r.v.who ? dbg_rdata : pipe_rdata), 32'(r.v.exp_rdata));
          chk("resp_err", 32'(resp_err), 32'(r.v.exp_err));
          chk("latency", 32'(cyc - r.issue), 32'(r.v.exp_lat));
          last_rd[r.v.who] = r.v.exp_rdata;
          chk("other_rdata_held", 32'(r.v.who ? pipe_rdata : dbg_rdata),
              32'(last_rd[!r.v.who]));
        end
      end else begin
        chk("resp_err_no_done", 32'(resp_err), 32'd0);
      end
    end
  end

  // APB slave model: serves the scoreboard head, checks address phase stability
  int acc_n = 0;
  always @(negedge clk) begin
    if (!rst || !psel) begin
      pready  = 1'b0;
      pslverr = 1'b0;
      acc_n   = 0;
      prdata  = 16'($urandom);
    end else if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL psel_no_request: psel high with nothing pending (cycle %0d)", cyc);
    end else begin
      chk("paddr", 32'(paddr), 32'(sb[0].v.addr));
      chk("pwrite", 32'(pwrite), 32'(sb[0].v.wr));
      if (sb[0].v.wr) chk("pwdata", 32'(pwdata), 32'(sb[0].v.wdata));
      if (!penable) begin
        acc_n   = 0;
        pready  = 1'b0;
        pslverr = 1'b0;
      end else begin
        pready  = (acc_n == sb[0].v.waits);
        pslverr = pready & sb[0].v.err;
        prdata  = pready ? mem[paddr] : 16'($urandom);
        if (pready && sb[0].v.wr && !sb[0].v.err) mem[paddr] = pwdata;
        acc_n++;
      end
    end
  end

  task automatic drive(input bit who, input bit req, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who) begin
      dbg_req = req; dbg_wr = wr; dbg_addr = a; dbg_wdata = d;
    end else begin
      pipe_req = req; pipe_wr = wr; pipe_addr = a; pipe_wdata = d;
    end
  endtask

  task automatic push(input vec_t v, input int issue);
    sb_t r;
    r.v     = v;
    r.issue = issue;
    sb.push_back(r);
  endtask

  task automatic wait_done(input bit who, input int budget, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = who ? dbg_done : pipe_done;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no done within %0d cycles (cycle %0d)", name, budget, cyc);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    drive(v.who, 1'b1, v.wr, v.addr, v.wdata);
    push(v, cyc);
    #1 chk("stall_on_req", 32'(stall_flg), 32'(!v.who));
    wait_done(v.who, v.exp_lat + 8, name);
    chk("stall_at_done", 32'(stall_flg), 32'd0);
    @(negedge clk);
    drive(v.who, 1'b0, 1'b0, '0, '0);
    #1 chk("stall_idle", 32'(stall_flg), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c;
    vec_t v;

    for (int i = 0; i < 64; i++) mem[i] = 16'hA500 | 16'(i);
    mem[5]     = 16'hBEEF;
    mem[6'h10] = 16'hFFFF;
    last_rd[0] = '0;
    last_rd[1] = '0;

    //            who   wr    addr   wdata     waits err   exp_rd    e_err lat
    tbl[0]  = '{1'b0, 1'b0, 6'h05, 16'h0000, 0,   1'b0, 16'hBEEF, 1'b0, 3};
    tbl[1]  = '{1'b1, 1'b1, 6'h3F, 16'h1234, 2,   1'b0, 16'hA507, 1'b0, 5};
    tbl[2]  = '{1'b1, 1'b0, 6'h3F, 16'h0000, 0,   1'b0, 16'h1234, 1'b0, 3};
    tbl[3]  = '{1'b0, 1'b0, 6'h10, 16'h0000, 0,   1'b1, 16'h0000, 1'b1, 3};
    tbl[4]  = '{1'b0, 1'b1, 6'h07, 16'hCAFE, 1,   1'b0, 16'h0000, 1'b0, 4};
    tbl[5]  = '{1'b0, 1'b0, 6'h07, 16'h0000, 0,   1'b0, 16'hCAFE, 1'b0, 3};
    tbl[6]  = '{1'b0, 1'b0, 6'h00, 16'h0000, 15,  1'b0, 16'hA500, 1'b0, 18};
    tbl[7]  = '{1'b1, 1'b0, 6'h01, 16'h0000, 255, 1'b0, 16'h0000, 1'b1, 18};
    tbl[8]  = '{1'b1, 1'b1, 6'h02, 16'h5555, 0,   1'b1, 16'h0000, 1'b1, 3};
    tbl[9]  = '{1'b1, 1'b0, 6'h02, 16'h0000, 3,   1'b0, 16'hA502, 1'b0, 6};
    tbl[10] = '{1'b0, 1'b0, 6'h3E, 16'h0000, 1,   1'b0, 16'hA53E, 1'b0, 4};
    tbl[11] = '{1'b1, 1'b0, 6'h05, 16'h0000, 0,   1'b0, 16'hBEEF, 1'b0, 3};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", 32'(pwdata), 32'd0);
    chk("rst_pipe_rdata", 32'(pipe_rdata), 32'd0);
    chk("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
    chk("rst_pipe_done", 32'(pipe_done), 32'd0);
    chk("rst_dbg_done", 32'(dbg_done), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_stall", 32'(stall_flg), 32'd0);
    rst = 1'b1;

    // contention straight out of reset: pipe, dbg, pipe, dbg, 4 cycles apart
    @(negedge clk);
    c = cyc;
    drive(1'b0, 1'b1, 1'b0, 6'h05, '0);
    drive(1'b1, 1'b1, 1'b0, 6'h07, '0);
    for (int k = 0; k < 4; k++) begin
      v = '{1'(k % 2), 1'b0, (k % 2 == 1) ? 6'h07 : 6'h05, 16'h0000, 0, 1'b0,
            (k % 2 == 1) ? 16'hA507 : 16'hBEEF, 1'b0, 3 + 4 * k};
      push(v, c);
    end
    for (int k = 0; k < 4; k++) wait_done(1'(k % 2), 8, "contention");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);

    // table of single-requester transfers
    for (int i = 0; i < 12; i++) run_vec(tbl[i], "vec");

    // stuck slave on a pipeline load with a debug load queued behind it
    @(negedge clk);
    c = cyc;
    drive(1'b0, 1'b1, 1'b0, 6'h01, '0);
    push('{1'b0, 1'b0, 6'h01, 16'h0000, 255, 1'b0, 16'h0000, 1'b1, 18}, c);
    repeat (2) @(negedge clk);
    chk("to_penable_rise", 32'(penable), 32'd1);
    repeat (3) @(negedge clk);
    chk("to_stall", 32'(stall_flg), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 6'h3F, '0);
    push('{1'b1, 1'b0, 6'h3F, 16'h0000, 0, 1'b0, 16'h1234, 1'b0, 22}, c);
    wait_done(1'b0, 20, "timeout_pipe");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    wait_done(1'b1, 8, "timeout_queued_dbg");
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, '0, '0);

    // reset during ACCESS aborts the transfer without a done
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 6'h09, '0);
    push('{1'b0, 1'b0, 6'h09, 16'h0000, 255, 1'b0, 16'h0000, 1'b1, 18}, cyc);
    repeat (2) @(negedge clk);
    chk("mid_penable", 32'(penable), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_psel", 32'(psel), 32'd0);
    chk("arst_penable", 32'(penable), 32'd0);
    chk("arst_pipe_done", 32'(pipe_done), 32'd0);
    chk("arst_dbg_done", 32'(dbg_done), 32'd0);
    chk("arst_dbg_rdata", 32'(dbg_rdata), 32'd0);
    sb.delete();
    last_rd[0] = '0;
    last_rd[1] = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_vec('{1'b0, 1'b0, 6'h05, 16'h0000, 0, 1'b0, 16'hBEEF, 1'b0, 3}, "post_reset");

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
